sram_addr_gen: RTL and testbench

//  Parametrised, pipelined successor to the per-object SRAM address encoder. Maps (object id,

---
 rtl/game_pkg.sv | 15 +
 rtl/sram_pkg.sv | 27 ++
 rtl/sram_obj_table.sv | 86 ++++++++
 rtl/sram_addr_gen.sv | 172 +++++++++++++++++
 tb/tb_sram_addr_gen.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Game-level object identifiers; each value selects one row of the SRAM object table.
package game_pkg;

  typedef enum logic [3:0] {
    OBJECT_MAP     = 4'd0,
    OBJECT_PLAYER  = 4'd1,
    OBJECT_ENEMY   = 4'd2,
    OBJECT_BULLET  = 4'd3,
    OBJECT_ITEM    = 4'd4,
    OBJECT_HUD     = 4'd5,
    OBJECT_FONT    = 4'd6,
    OBJECT_EFFECT  = 4'd7
  } object_id_e;

endpackage

// File: rtl/sram_pkg.sv
// SRAM layout defaults: per-object base word address and pixel size loaded into the table at reset.
package sram_pkg;

  localparam int ADDR_W_DEF   = 20;
  localparam int PPW_LOG2_DEF = 2;
  localparam int MAX_OBJ      = 16;

  // Object 0 is the 640x480 map (76800 words at 4 px/word); the rest get 2048-word slots after it.
  localparam logic [31:0] OBJ_BASE_DEFAULT [MAX_OBJ] = '{
    32'h00000, 32'h13000, 32'h13800, 32'h14000,
    32'h14800, 32'h15000, 32'h15800, 32'h16000,
    32'h16800, 32'h17000, 32'h17800, 32'h18000,
    32'h18800, 32'h19000, 32'h19800, 32'h1A000
  };

  localparam logic [31:0] OBJ_SIZE_DEFAULT [MAX_OBJ] = '{
    32'd307200, 32'd8192, 32'd8192, 32'd8192,
    32'd8192,   32'd8192, 32'd8192, 32'd8192,
    32'd8192,   32'd8192, 32'd8192, 32'd8192,
    32'd8192,   32'd8192, 32'd8192, 32'd8192
  };

  function automatic int sub_w(input int ppw_log2);
    return (ppw_log2 > 0) ? ppw_log2 : 1;
  endfunction

endpackage

// File: rtl/sram_obj_table.sv
// Per-object base/size register file: one write port, one registered lookup port.
// Lookup of an id outside the table returns base 0, size 0 and hit 0.
module sram_obj_table
  import sram_pkg::*;
#(
  parameter int NUM_OBJ   = 16,
  parameter int OBJ_ID_W  = 4,
  parameter int ADDR_W    = 20,
  parameter int PIX_IDX_W = 19
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [OBJ_ID_W-1:0]  i_wr_id,
  input  logic [ADDR_W-1:0]    i_wr_base,
  input  logic [PIX_IDX_W-1:0] i_wr_size,
  input  logic                 i_rd_en,
  input  logic [OBJ_ID_W-1:0]  i_rd_id,
  output logic [ADDR_W-1:0]    o_rd_base,
  output logic [PIX_IDX_W-1:0] o_rd_size,
  output logic                 o_rd_hit
);

  logic [ADDR_W-1:0]    r_base [NUM_OBJ];
  logic [PIX_IDX_W-1:0] r_size [NUM_OBJ];
  logic [NUM_OBJ-1:0]   w_wr_sel;
  logic [ADDR_W-1:0]    w_rd_base;
  logic [PIX_IDX_W-1:0] w_rd_size;
  logic                 w_rd_hit;
  logic [ADDR_W-1:0]    r_rd_base;
  logic [PIX_IDX_W-1:0] r_rd_size;
  logic                 r_rd_hit;

  generate
    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_wr_sel
      assign w_wr_sel[gi] = i_we && (i_wr_id == OBJ_ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_OBJ; k++) begin
        r_base[k] <= OBJ_BASE_DEFAULT[k][ADDR_W-1:0];
        r_size[k] <= OBJ_SIZE_DEFAULT[k][PIX_IDX_W-1:0];
      end
    end else begin
      for (int k = 0; k < NUM_OBJ; k++) begin
        if (w_wr_sel[k]) begin
          r_base[k] <= i_wr_base;
          r_size[k] <= i_wr_size;
        end
      end
    end
  end

  always_comb begin
    w_rd_base = '0;
    w_rd_size = '0;
    w_rd_hit  = 1'b0;
    for (int k = 0; k < NUM_OBJ; k++) begin
      if (i_rd_id == OBJ_ID_W'(k)) begin
        w_rd_base = r_base[k];
        w_rd_size = r_size[k];
        w_rd_hit  = 1'b1;
      end
    end
  end

  // Read samples the array before this edge's write lands, so a same-cycle write is not seen.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_base <= '0;
      r_rd_size <= '0;
      r_rd_hit  <= 1'b0;
    end else if (i_rd_en) begin
      r_rd_base <= w_rd_base;
      r_rd_size <= w_rd_size;
      r_rd_hit  <= w_rd_hit;
    end
  end

  assign o_rd_base = r_rd_base;
  assign o_rd_size = r_rd_size;
  assign o_rd_hit  = r_rd_hit;

endmodule

// File: rtl/sram_addr_gen.sv
// Pipelined (object id, pixel index) -> packed-pixel SRAM word address and lane, with bounds
// checking, valid/ready flow control and a saturating out-of-bounds counter.
module sram_addr_gen
  import sram_pkg::*;
#(
  parameter int NUM_OBJ   = 16,
  parameter int OBJ_ID_W  = 4,
  parameter int PIX_IDX_W = 19,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int PPW_LOG2  = PPW_LOG2_DEF,
  parameter int CNT_W     = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cfg_we,
  input  logic [OBJ_ID_W-1:0]        i_cfg_id,
  input  logic [ADDR_W-1:0]          i_cfg_base,
  input  logic [PIX_IDX_W-1:0]       i_cfg_size,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [OBJ_ID_W-1:0]        i_object_id,
  input  logic [PIX_IDX_W-1:0]       i_pixel_index,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [ADDR_W-1:0]          o_sram_addr,
  output logic [sub_w(PPW_LOG2)-1:0] o_sub_sel,
  output logic [OBJ_ID_W-1:0]        o_object_id,
  output logic                       o_oob,
  input  logic                       i_oob_clr,
  output logic [CNT_W-1:0]           o_oob_count
);

  localparam int SUB_W = sub_w(PPW_LOG2);

  logic                 w_accept, w_s1_load, w_out_load;
  logic [ADDR_W-1:0]    w_lk_base;
  logic [PIX_IDX_W-1:0] w_lk_size;
  logic                 w_lk_hit, w_oob, w_oob_evt;
  logic [ADDR_W-1:0]    w_off;
  logic [SUB_W-1:0]     w_sub;

  logic                 r_lk_valid, r_lk_new;
  logic [OBJ_ID_W-1:0]  r_lk_id;
  logic [PIX_IDX_W-1:0] r_lk_pix;
  logic                 r_s1_valid, r_s1_oob;
  logic [ADDR_W-1:0]    r_s1_base, r_s1_off;
  logic [SUB_W-1:0]     r_s1_sub;
  logic [OBJ_ID_W-1:0]  r_s1_id;
  logic                 r_out_valid, r_out_oob;
  logic [ADDR_W-1:0]    r_out_addr;
  logic [SUB_W-1:0]     r_out_sub;
  logic [OBJ_ID_W-1:0]  r_out_id;
  logic                 r_clr_d;
  logic [CNT_W-1:0]     r_cnt;

  assign w_out_load  = r_s1_valid && (!r_out_valid || i_rsp_ready);
  assign w_s1_load   = r_lk_valid && (!r_s1_valid || w_out_load);
  assign o_req_ready = !r_lk_valid || w_s1_load;
  assign w_accept    = i_req_valid && o_req_ready;

  sram_obj_table #(
    .NUM_OBJ   (NUM_OBJ),
    .OBJ_ID_W  (OBJ_ID_W),
    .ADDR_W    (ADDR_W),
    .PIX_IDX_W (PIX_IDX_W)
  ) u_table (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we      (i_cfg_we),
    .i_wr_id   (i_cfg_id),
    .i_wr_base (i_cfg_base),
    .i_wr_size (i_cfg_size),
    .i_rd_en   (w_accept),
    .i_rd_id   (i_object_id),
    .o_rd_base (w_lk_base),
    .o_rd_size (w_lk_size),
    .o_rd_hit  (w_lk_hit)
  );

  assign w_oob = !w_lk_hit || (r_lk_pix >= w_lk_size);
  assign w_off = ADDR_W'(r_lk_pix >> PPW_LOG2);

  generate
    if (PPW_LOG2 > 0) begin : g_lane
      assign w_sub = r_lk_pix[SUB_W-1:0];
    end else begin : g_no_lane
      assign w_sub = '0;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lk_valid <= 1'b0;
      r_lk_new   <= 1'b0;
      r_lk_id    <= '0;
      r_lk_pix   <= '0;
    end else begin
      r_lk_new <= w_accept;
      if (w_accept) begin
        r_lk_valid <= 1'b1;
        r_lk_id    <= i_object_id;
        r_lk_pix   <= i_pixel_index;
      end else if (w_s1_load) begin
        r_lk_valid <= 1'b0;
      end
    end
  end

  // An out-of-bounds entry carries zero offset and lane so the final add yields the bare base.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_oob   <= 1'b0;
      r_s1_base  <= '0;
      r_s1_off   <= '0;
      r_s1_sub   <= '0;
      r_s1_id    <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= 1'b1;
      r_s1_oob   <= w_oob;
      r_s1_base  <= w_lk_base;
      r_s1_off   <= w_oob ? '0 : w_off;
      r_s1_sub   <= w_oob ? '0 : w_sub;
      r_s1_id    <= r_lk_id;
    end else if (w_out_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_oob   <= 1'b0;
      r_out_addr  <= '0;
      r_out_sub   <= '0;
      r_out_id    <= '0;
    end else if (w_out_load) begin
      r_out_valid <= 1'b1;
      r_out_oob   <= r_s1_oob;
      r_out_addr  <= r_s1_base + r_s1_off;
      r_out_sub   <= r_s1_sub;
      r_out_id    <= r_s1_id;
    end else if (o_rsp_valid && i_rsp_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // OOB is only known one cycle after accept; delaying clr by the same cycle keeps their ordering.
  assign w_oob_evt = r_lk_new && w_oob;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clr_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_clr_d <= i_oob_clr;
      if (r_clr_d) begin
        r_cnt <= w_oob_evt ? CNT_W'(1) : '0;
      end else if (w_oob_evt && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_rsp_valid = r_out_valid;
  assign o_sram_addr = r_out_addr;
  assign o_sub_sel   = r_out_sub;
  assign o_object_id = r_out_id;
  assign o_oob       = r_out_oob;
  assign o_oob_count = r_cnt;

endmodule

// File: tb/tb_sram_addr_gen.sv
// Directed + randomized bench for sram_addr_gen against a transaction-level table/counter model.
module tb_sram_addr_gen;
  import sram_pkg::*;
  import game_pkg::*;

  localparam int NUM = 14;

  typedef struct packed {
    logic [19:0] addr;
    logic [1:0]  sub;
    logic [3:0]  id;
    logic        oob;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_id = '0;
  logic [19:0] cfg_base = '0;
  logic [18:0] cfg_size = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  object_id = '0;
  logic [18:0] pixel_index = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [19:0] sram_addr;
  logic [1:0]  sub_sel;
  logic [3:0]  rsp_id;
  logic        oob;
  logic        oob_clr = 1'b0;
  logic [15:0] oob_count;

  sram_addr_gen #(
    .NUM_OBJ(NUM), .OBJ_ID_W(4), .PIX_IDX_W(19), .ADDR_W(20), .PPW_LOG2(2), .CNT_W(16)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cfg_we(cfg_we), .i_cfg_id(cfg_id), .i_cfg_base(cfg_base), .i_cfg_size(cfg_size),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_object_id(object_id), .i_pixel_index(pixel_index),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_sram_addr(sram_addr), .o_sub_sel(sub_sel), .o_object_id(rsp_id), .o_oob(oob),
    .i_oob_clr(oob_clr), .o_oob_count(oob_count)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  int   n_rsp = 0;
  int   m_base [16];
  int   m_size [16];
  int   m_count = 0;
  rsp_t q [$];
  bit   stall_prev = 0;
  rsp_t held;
  bit   last_acc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_base[i] = int'(OBJ_BASE_DEFAULT[i]);
      m_size[i] = int'(OBJ_SIZE_DEFAULT[i]);
    end
    m_count = 0;
    q.delete();
    stall_prev = 0;
  endtask

  function automatic rsp_t model(input int id, input int pix);
    rsp_t r;
    r.id = 4'(id);
    if (id >= NUM) begin
      r.oob = 1'b1; r.addr = '0; r.sub = '0;
    end else if (pix >= m_size[id]) begin
      r.oob = 1'b1; r.addr = 20'(m_base[id]); r.sub = '0;
    end else begin
      r.oob  = 1'b0;
      r.addr = 20'((m_base[id] + pix / 4) % (1 << 20));
      r.sub  = 2'(pix % 4);
    end
    return r;
  endfunction

  task automatic req(input bit v, input int id, input int pix);
    req_valid   = v;
    object_id   = 4'(id);
    pixel_index = 19'(pix);
  endtask

  task automatic cfg(input bit we, input int id, input int base, input int size);
    cfg_we = we; cfg_id = 4'(id); cfg_base = 20'(base); cfg_size = 19'(size);
  endtask

  // One clock: score the response/stall/accept seen before the edge, update model, advance.
  task automatic tick();
    rsp_t seen, e;
    bit   acc_oob;
    #1;
    seen = {sram_addr, sub_sel, rsp_id, oob};
    if (stall_prev) check("stall_hold", {rsp_valid, seen}, {1'b1, held});
    stall_prev = rsp_valid && !rsp_ready;
    held = seen;
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      check("rsp_pending", q.size() > 0, 1'b1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("rsp", seen, e);
      end
    end
    last_acc = req_valid && req_ready;
    acc_oob = 1'b0;
    if (last_acc) begin
      e = model(int'(object_id), int'(pixel_index));
      q.push_back(e);
      acc_oob = e.oob;
    end
    if (oob_clr) m_count = acc_oob ? 1 : 0;
    else if (acc_oob && m_count < 65535) m_count++;
    if (cfg_we && int'(cfg_id) < NUM) begin
      m_base[cfg_id] = int'(cfg_base);
      m_size[cfg_id] = int'(cfg_size);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req(0, 0, 0); cfg(0, 0, 0, 0); rsp_ready = 1'b1; oob_clr = 1'b0;
    for (int i = 0; i < 40 && (q.size() > 0 || rsp_valid); i++) tick();
    tick();
    tick();
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, start_rsp, id, pix, sel;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_sub", sub_sel, 0);
    check("rst_id", rsp_id, 0);
    check("rst_oob", oob, 0);
    check("rst_count", oob_count, 0);
    check("rst_req_ready", req_ready, 1);

    // 1: default map entry, latency of two edges after accept
    req(1, int'(OBJECT_MAP), 13);
    tick();
    req(0, 0, 0);
    check("lat_n0", rsp_valid, 0);
    tick();
    check("lat_n1", rsp_valid, 0);
    tick();
    check("lat_n2", rsp_valid, 1);
    check("t1_addr", sram_addr, 20'h00003);
    check("t1_sub", sub_sel, 1);
    check("t1_oob", oob, 0);
    drain();
    $display("step t1 done responses=%0d", n_rsp);

    // 2: reprogram id 3 and probe the last in-bounds and first out-of-bounds pixel
    cfg(1, 3, 'h1F000, 4096); tick(); cfg(0, 0, 0, 0);
    req(1, 3, 4095); tick();
    req(1, 3, 4096); tick();
    drain();
    check("t2_count", oob_count, 1);
    $display("step t2 done count=%0d", oob_count);

    // 3: write and request to the same id in one cycle use the old entry
    cfg(1, 3, 'h20000, 4096); req(1, 3, 8); tick();
    cfg(0, 0, 0, 0); req(1, 3, 8); tick();
    drain();
    $display("step t3 done responses=%0d", n_rsp);

    // 5: address wrap, size zero, invalid ids at the table boundary
    cfg(1, 5, 'hFFFFF, 100); tick();
    cfg(1, 7, 0, 0); tick(); cfg(0, 0, 0, 0);
    req(1, 5, 8); tick();
    req(1, 7, 0); tick();
    req(1, 15, 0); tick();
    req(1, 14, 0); tick();
    req(1, 13, 8191); tick();
    drain();
    check("t5_count", oob_count, 4);
    $display("step t5 done count=%0d", oob_count);

    // 4: 64 back-to-back requests with the consumer toggling ready every cycle
    start_rsp = n_rsp;
    sent = 0;
    for (int cyc = 0; cyc < 1000 && sent < 64; cyc++) begin
      rsp_ready = cyc[0];
      id = $urandom_range(0, 15);
      pix = (id < NUM) ? $urandom_range(0, m_size[id]) : $urandom_range(0, 1000);
      req(1, id, pix);
      tick();
      if (last_acc) sent++;
    end
    drain();
    check("t4_sent", sent, 64);
    check("t4_rsp_count", n_rsp - start_rsp, 64);
    check("t4_count", oob_count, 16'(m_count));
    $display("step t4 done responses=%0d", n_rsp - start_rsp);

    // random mix of requests, backpressure, table writes and clears
    for (int cyc = 0; cyc < 400; cyc++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      oob_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0)
        cfg(1, $urandom_range(0, 15), $urandom, $urandom_range(0, 8192));
      else
        cfg(0, 0, 0, 0);
      id = $urandom_range(0, 15);
      sel = $urandom_range(0, 3);
      pix = (id >= NUM) ? $urandom_range(0, 100) :
            (sel == 0) ? m_size[id] - 1 : (sel == 1) ? m_size[id] :
            (sel == 2) ? $urandom_range(0, 524287) : $urandom_range(0, 64);
      req($urandom_range(0, 2) != 0, id, pix);
      tick();
    end
    drain();
    check("rand_count", oob_count, 16'(m_count));
    $display("step random done responses=%0d", n_rsp);

    // 6: counter saturation and clear coinciding with an OOB accept
    oob_clr = 1'b1; tick(); oob_clr = 1'b0;
    repeat (65535) begin
      req(1, 15, $urandom_range(0, 1000));
      tick();
    end
    drain();
    check("sat_reach", oob_count, 16'hFFFF);
    req(1, 15, 0); tick();
    drain();
    check("sat_hold", oob_count, 16'hFFFF);
    req(1, 15, 0); oob_clr = 1'b1; tick();
    drain();
    check("clr_coincide", oob_count, 1);
    check("clr_model", oob_count, 16'(m_count));
    $display("step t6 counter done count=%0d", oob_count);

    // reset with requests in flight
    cfg(1, 3, 'h0ABCD, 50); tick(); cfg(0, 0, 0, 0);
    rsp_ready = 1'b0;
    req(1, 3, 8); tick();
    req(1, 3, 9); tick();
    req(0, 0, 0); tick();
    check("inflight_valid", rsp_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_valid", rsp_valid, 0);
    rst = 1'b0;
    model_reset();
    rsp_ready = 1'b1;
    repeat (5) tick();
    check("no_stale", n_rsp >= 0 && q.size() == 0 && rsp_valid == 0, 1);
    check("rst_mid_count", oob_count, 0);
    req(1, 3, 8); tick();
    drain();
    $display("step reset done responses=%0d", n_rsp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
